// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer arbiter: pixel and address
// widths, the frame size, and the write-FIFO entry layout.
package fb_pkg;

  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 8;
  localparam int FRAME_PIXELS = 76800;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } fb_wr_entry_t;

  localparam fb_addr_t LAST_ADDR = fb_addr_t'(FRAME_PIXELS - 1);

  // Sequential frame address with wrap after the last pixel of the frame.
  function automatic fb_addr_t next_addr(input fb_addr_t a);
    return (a == LAST_ADDR) ? '0 : a + fb_addr_t'(1);
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of display-read, camera-write and BRAM signals around fb_arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface fb_arbiter_if;
  import fb_pkg::*;

  logic     rd_req;
  fb_addr_t rd_addr;
  logic     rd_valid;
  pixel_t   rd_data;

  logic     wr_valid;
  logic     wr_sof;
  pixel_t   wr_data;

  logic     mem_en;
  logic     mem_we;
  fb_addr_t mem_addr;
  pixel_t   mem_wdata;
  pixel_t   mem_rdata;

  logic     fifo_full;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_sof, wr_data, mem_rdata,
    output rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, fifo_full
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_sof, wr_data, mem_rdata,
    input  rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_wdata, fifo_full
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Register-based synchronous FIFO of pending camera writes. A push while full
// is taken only when a pop happens in the same cycle; pop while empty is ignored.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  fb_wr_entry_t i_entry,
  output fb_wr_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fb_wr_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads always win, buffered camera writes
// drain into idle BRAM cycles. Optional FB_DROP_CNT_EN adds a dropped-pixel counter.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               pclk,
  input  logic               rst_n,
  fb_arbiter_if.slave        bus
`ifdef FB_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  fb_addr_t     r_wa;
  logic         r_mem_en;
  logic         r_mem_we;
  fb_addr_t     r_mem_addr;
  pixel_t       r_mem_wdata;
  logic         r_rd_valid;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  fb_wr_entry_t w_entry;
  fb_wr_entry_t w_head;

  // Reads take the port unconditionally; a write only pops when no read is asked.
  assign w_pop  = !bus.rd_req && !w_empty;
  assign w_push = bus.wr_valid && (!w_full || w_pop);

  assign w_entry.addr = bus.wr_sof ? '0 : r_wa;
  assign w_entry.data = bus.wr_data;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .i_push  (bus.wr_valid),
    .i_pop   (w_pop),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The address advances for every strobed pixel, dropped or not, to keep frame alignment.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa <= '0;
    end else if (bus.wr_valid) begin
      r_wa <= bus.wr_sof ? next_addr('0) : next_addr(r_wa);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_mem_en   <= bus.rd_req || w_pop;
      r_mem_we   <= w_pop;
      r_rd_valid <= r_mem_en && !r_mem_we;
      if (bus.rd_req) begin
        r_mem_addr <= bus.rd_addr;
      end else if (w_pop) begin
        r_mem_addr  <= w_head.addr;
        r_mem_wdata <= w_head.data;
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.fifo_full = w_full;

`ifdef FB_DROP_CNT_EN
  logic        w_drop;
  logic        w_sof_taken;
  logic [15:0] r_drop_cnt;

  assign w_drop      = bus.wr_valid && !w_push;
  assign w_sof_taken = bus.wr_valid && bus.wr_sof && w_push;

  // A dropped sof pixel is counted against the frame it failed to start.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_sof_taken) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: reset, write stream, read priority, wrap,
// overflow and full push/pop, with a small BRAM read model.
module tb_fb_arbiter;
  import fb_pkg::*;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;

  fb_arbiter_if bus();

`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fb_arbiter #(.FIFO_DEPTH(8)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // BRAM model: read data is a fixed function of the address, one cycle late.
  always @(posedge pclk)
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[7:0] ^ 8'h5A;

  typedef struct {
    int       c;
    fb_addr_t a;
    pixel_t   d;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t vq[$];

  always @(negedge pclk) begin
    if (bus.mem_en && bus.mem_we)  wq.push_back('{cyc, bus.mem_addr, bus.mem_wdata});
    if (bus.mem_en && !bus.mem_we) rq.push_back('{cyc, bus.mem_addr, 8'h00});
    if (bus.rd_valid)              vq.push_back('{cyc, '0, bus.rd_data});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    bus.wr_data  = '0;
  endtask

  task automatic clear_logs();
    wq.delete();
    rq.delete();
    vq.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_logs();
  endtask

  task automatic test_reset();
    int pe;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_init_mem_en: got %b expected 0", bus.mem_en); end
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_init_rd_valid: got %b expected 0", bus.rd_valid); end
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_init_fifo_full: got %b expected 0", bus.fifo_full); end
    step(2);
    rst_n = 1'b1;
    step(1);
    // Fill the FIFO behind a read stream so every output is non-zero before reset.
    for (int k = 0; k < 8; k++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = fb_addr_t'(5);
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (k == 0);
      bus.wr_data  = pixel_t'(32 + k);
      step();
    end
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL reset_prefill_full: got %b expected 1", bus.fifo_full); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_async_mem_en: got %b expected 0", bus.mem_en); end
    n_checks++;
    if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_async_mem_addr: got %0h expected 0", bus.mem_addr); end
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async_rd_valid: got %b expected 0", bus.rd_valid); end
    n_checks++;
    if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_async_fifo_full: got %b expected 0", bus.fifo_full); end
    idle_inputs();
    step(1);
    rst_n = 1'b1;
    step(1);
    clear_logs();
    bus.wr_valid = 1'b1;
    bus.wr_sof   = 1'b1;
    bus.wr_data  = 8'h77;
    step();
    pe = cyc;
    idle_inputs();
    step(3);
    n_checks++;
    if (wq.size() !== 1) begin n_fail++; $display("FAIL reset_after_count: got %0d expected 1", wq.size()); end
    if (wq.size() > 0) begin
      n_checks++;
      if (wq[0].a !== '0 || wq[0].d !== 8'h77 || wq[0].c !== pe + 1) begin
        n_fail++;
        $display("FAIL reset_after_write: got addr %0h data %0h cyc %0d expected addr 0 data 77 cyc %0d",
                 wq[0].a, wq[0].d, wq[0].c, pe + 1);
      end
    end
  endtask

  task automatic test_write_stream();
    int pc[7];
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (k == 0) || (k == 6);
      bus.wr_data  = (k == 6) ? 8'hEE : pixel_t'(16 + k);
      step();
      pc[k] = cyc;
    end
    idle_inputs();
    step(3);
    n_checks++;
    if (wq.size() !== 7) begin n_fail++; $display("FAIL stream_count: got %0d expected 7", wq.size()); end
    for (int k = 0; k < 7 && k < wq.size(); k++) begin
      // Pixel 6 is a fresh sof, so it restarts at address 0.
      n_checks++;
      if (wq[k].a !== ((k == 6) ? fb_addr_t'(0) : fb_addr_t'(k))) begin
        n_fail++; $display("FAIL stream_addr[%0d]: got %0h expected %0h", k, wq[k].a, (k == 6) ? 0 : k);
      end
      n_checks++;
      if (wq[k].d !== ((k == 6) ? 8'hEE : pixel_t'(16 + k))) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", k, wq[k].d, (k == 6) ? 8'hEE : 16 + k);
      end
      n_checks++;
      if (wq[k].c !== pc[k] + 1) begin
        n_fail++; $display("FAIL stream_latency[%0d]: got cyc %0d expected %0d", k, wq[k].c, pc[k] + 1);
      end
    end
  endtask

  task automatic test_read_priority();
    int e0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 17'h12C00;
      bus.wr_valid = (k < 3);
      bus.wr_sof   = (k == 0);
      bus.wr_data  = pixel_t'(48 + k);
      step();
      if (k == 0) e0 = cyc;
    end
    idle_inputs();
    step(8);
    n_checks++;
    if (rq.size() !== 4) begin n_fail++; $display("FAIL prio_read_count: got %0d expected 4", rq.size()); end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      n_checks++;
      if (rq[k].a !== 17'h12C00 || rq[k].c !== e0 + k) begin
        n_fail++; $display("FAIL prio_read[%0d]: got addr %0h cyc %0d expected addr 12c00 cyc %0d", k, rq[k].a, rq[k].c, e0 + k);
      end
    end
    n_checks++;
    if (vq.size() !== 4) begin n_fail++; $display("FAIL prio_valid_count: got %0d expected 4", vq.size()); end
    for (int k = 0; k < 4 && k < vq.size(); k++) begin
      n_checks++;
      if (vq[k].d !== 8'h5A || vq[k].c !== e0 + 1 + k) begin
        n_fail++; $display("FAIL prio_valid[%0d]: got data %0h cyc %0d expected data 5a cyc %0d", k, vq[k].d, vq[k].c, e0 + 1 + k);
      end
    end
    n_checks++;
    if (wq.size() !== 3) begin n_fail++; $display("FAIL prio_write_count: got %0d expected 3", wq.size()); end
    for (int k = 0; k < 3 && k < wq.size(); k++) begin
      n_checks++;
      if (wq[k].a !== fb_addr_t'(k) || wq[k].d !== pixel_t'(48 + k) || wq[k].c !== e0 + 4 + k) begin
        n_fail++;
        $display("FAIL prio_write[%0d]: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                 k, wq[k].a, wq[k].d, wq[k].c, k, 48 + k, e0 + 4 + k);
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 76801; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (i == 0);
      bus.wr_data  = pixel_t'(i);
      step();
    end
    idle_inputs();
    step(3);
    n = wq.size();
    n_checks++;
    if (n !== 76801) begin n_fail++; $display("FAIL wrap_count: got %0d expected 76801", n); end
    if (n >= 2) begin
      n_checks++;
      if (wq[n-1].a !== '0 || wq[n-1].d !== 8'h00) begin
        n_fail++; $display("FAIL wrap_last: got addr %0h data %0h expected addr 0 data 0", wq[n-1].a, wq[n-1].d);
      end
      n_checks++;
      if (wq[n-2].a !== fb_addr_t'(76799) || wq[n-2].d !== 8'hFF) begin
        n_fail++; $display("FAIL wrap_prev: got addr %0h data %0h expected addr 12bff data ff", wq[n-2].a, wq[n-2].d);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      bus.rd_req   = 1'b1;
      bus.rd_addr  = fb_addr_t'(k);
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (k == 0);
      bus.wr_data  = pixel_t'(64 + k);
      step();
      if (k == 7) begin
        n_checks++;
        if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", bus.fifo_full); end
      end
    end
`ifdef FB_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 4", drop_cnt); end
`endif
    idle_inputs();
    step(10);
    n_checks++;
    if (vq.size() !== 12) begin n_fail++; $display("FAIL ovf_read_count: got %0d expected 12", vq.size()); end
    if (vq.size() > 5) begin
      n_checks++;
      if (vq[5].d !== 8'h5F) begin n_fail++; $display("FAIL ovf_read_data: got %0h expected 5f", vq[5].d); end
    end
    n_checks++;
    if (wq.size() !== 8) begin n_fail++; $display("FAIL ovf_write_count: got %0d expected 8", wq.size()); end
    for (int k = 0; k < 8 && k < wq.size(); k++) begin
      n_checks++;
      if (wq[k].a !== fb_addr_t'(k) || wq[k].d !== pixel_t'(64 + k)) begin
        n_fail++; $display("FAIL ovf_write[%0d]: got addr %0h data %0h expected addr %0h data %0h", k, wq[k].a, wq[k].d, k, 64 + k);
      end
    end
    // Dropped pixels still consumed addresses 8..11, so the next one lands at 12.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    step();
    idle_inputs();
    step(3);
    n_checks++;
    if (wq.size() !== 9) begin n_fail++; $display("FAIL ovf_next_count: got %0d expected 9", wq.size()); end
    if (wq.size() > 8) begin
      n_checks++;
      if (wq[8].a !== fb_addr_t'(12) || wq[8].d !== 8'h55) begin
        n_fail++; $display("FAIL ovf_next_write: got addr %0h data %0h expected addr c data 55", wq[8].a, wq[8].d);
      end
    end
`ifdef FB_DROP_CNT_EN
    bus.wr_valid = 1'b1;
    bus.wr_sof   = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL ovf_drop_clear: got %0d expected 0", drop_cnt); end
    step(3);
`endif
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.rd_req   = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (k == 0);
      bus.wr_data  = pixel_t'(96 + k);
      step();
    end
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL fpp_full_before: got %b expected 1", bus.fifo_full); end
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_sof   = 1'b0;
    bus.wr_data  = 8'h99;
    step();
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL fpp_full_after: got %b expected 1", bus.fifo_full); end
    bus.rd_req   = 1'b1;
    bus.wr_valid = 1'b0;
    step();
    n_checks++;
    if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL fpp_full_hold: got %b expected 1", bus.fifo_full); end
    idle_inputs();
    step(12);
    n_checks++;
    if (wq.size() !== 9) begin n_fail++; $display("FAIL fpp_write_count: got %0d expected 9", wq.size()); end
    if (wq.size() > 8) begin
      n_checks++;
      if (wq[0].a !== '0 || wq[0].d !== 8'h60) begin
        n_fail++; $display("FAIL fpp_first: got addr %0h data %0h expected addr 0 data 60", wq[0].a, wq[0].d);
      end
      n_checks++;
      if (wq[8].a !== fb_addr_t'(8) || wq[8].d !== 8'h99) begin
        n_fail++; $display("FAIL fpp_last: got addr %0h data %0h expected addr 8 data 99", wq[8].a, wq[8].d);
      end
    end
`ifdef FB_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL fpp_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_stream();
    test_read_priority();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Frame-buffer port arbiter and write sequencer for the QVGA camera path. It shares one single-port 320x240 frame-buffer BRAM between two requesters: the display scan-out, which reads at addresses it supplies, and the camera capture, which pushes a pixel stream with no backpressure. Camera pixels get sequential addresses generated here and are buffered in a small FIFO. Display reads always win arbitration, and camera writes drain into idle memory cycles.

## Interface
- ADDR_W, 17: frame-buffer address width.
- DATA_W, 8: pixel width (raw Bayer sample).
- FRAME_PIXELS, 76800: pixels per frame; write address wraps after FRAME_PIXELS-1.
- FIFO_DEPTH, 8: write FIFO entries; power of two, ≥2.

Ports:
- pclk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  display read request, one per cycle.
- rd_addr  in  ADDR_W  read address, valid with rd_req.
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_W  read pixel.
- wr_valid  in  1  camera pixel strobe.
- wr_sof  in  1  start of frame, qualified by wr_valid.
- wr_data  in  DATA_W  camera pixel.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en.
- fifo_full  out  1  write FIFO full; combinational from occupancy.

## Operation
- Write address counter `wa`:
  - A pixel with wr_valid=1 and wr_sof=1 takes address 0, and wa becomes 1.
  - A pixel with wr_valid=1 and wr_sof=0 takes wa, and wa increments.
  - wa wraps from FRAME_PIXELS-1 to 0.
- Push: each wr_valid pixel enqueues the entry {address, data}.
- Drop on full:
  - If the FIFO is full and no pop happens that cycle, the pixel is dropped.
  - wa still advances, so frame alignment is preserved.
  - If the FIFO is full and a pop happens the same cycle, the push is accepted.
- Arbitration, evaluated every cycle:
  - rd_req=1: issue a read (mem_en=1, mem_we=0, mem_addr=rd_addr).
  - rd_req=0 and FIFO not empty: pop the head and issue a write (mem_en=1, mem_we=1).
  - Otherwise: idle (mem_en=0).
- Reads have absolute priority. The system guarantees rd_req duty ≤50% averaged over any FIFO_DEPTH-cycle window. Violating this causes drops, never corruption.
- Read data: rd_data = mem_rdata (passthrough). rd_valid is a one-cycle-delayed copy of the issued-read flag.
- Reset, asynchronous, applies mid-frame or mid-access. Every output and state element is cleared:
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - rd_valid = 0.
  - FIFO emptied, so fifo_full = 0.
  - wa = 0.
  - Pending writes are lost.

## Timing
- All mem_* outputs are registered. A decision made in cycle N appears on the mem_* pins in cycle N+1.
- Read latency: rd_req in cycle N, then mem_en in N+1, then rd_valid/rd_data in N+2. One read per cycle, fully pipelined.
- Write latency: a pixel pushed in cycle N into an empty FIFO is eligible to pop in N+1. With rd_req low, it is written on the mem pins in N+2. No fall-through.
- FIFO occupancy updates on the clock edge. Push and pop in the same cycle leaves occupancy unchanged.

## Configuration
- FB_DROP_CNT_EN defined:
  - Adds output port drop_cnt (16 bits).
  - drop_cnt counts dropped pixels and saturates at 0xFFFF.
  - It clears on reset and on an accepted wr_sof pixel. The sof pixel is itself counted if it is dropped.
- Undefined: the drop_cnt port and its counter do not exist. Drop behaviour is identical.

## Structure
- Package fb_pkg holds:
  - ADDR_W, DATA_W and FRAME_PIXELS constants.
  - typedefs pixel_t and fb_addr_t.
  - struct packed fb_wr_entry_t {fb_addr_t addr; pixel_t data;}.
- Sub-module fb_wr_fifo:
  - Synchronous FIFO of fb_wr_entry_t with push, pop, full, empty.
  - Implemented with registers; no RAM inference required.
- The top level contains the address counter, the arbiter and the output registers.

## Test plan
- Reset check:
  - Stimulus: reset asserted mid-stream.
  - Response: mem_en=0, rd_valid=0 and fifo_full=0 immediately (asynchronously). After release, the next sof pixel is written to address 0.
- Write-only stream:
  - Stimulus: wr_sof at pixel 0, then 5 pixels 0x10..0x15 with rd_req=0.
  - Response: writes at addresses 0..5 with matching data, each 2 cycles after its push.
- Read priority:
  - Stimulus: rd_req=1 at address 0x12C00 for 4 cycles while 3 pixels are pushed.
  - Response: 4 reads, then 3 writes. rd_valid is high for 4 cycles, starting 2 cycles after the first rd_req.
- Wrap:
  - Stimulus: 76801 pixels with a single sof.
  - Response: the last write lands at address 0, and the previous one at 76799.
- Overflow:
  - Stimulus: rd_req held high for 12 cycles while 12 pixels are pushed (FIFO_DEPTH=8).
  - Response: 4 pixels dropped, then 8 writes. The 9th pixel's address is 8, so it is skipped. With FB_DROP_CNT_EN, drop_cnt=4.
- Simultaneous full push and pop:
  - Stimulus: FIFO full, rd_req=0, wr_valid=1.
  - Response: the push is accepted, occupancy stays 8, and there is no drop.
